// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared program/data memory port.
// slave = arbiter view, master = requesters plus memory array view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned NREQ = 3;

  // Requester side: 0 = instruction fetch, 1 = data access, 2 = loader/debug
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ-1:0]        lock;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic [1:0]             owner;

  // Memory array side
  logic                   mem_en;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req, we, lock, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, owner, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, lock, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, owner, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one single-port memory
// between instruction fetch, data access and the loader/debug port.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned NREQ   = 3;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    ARB = 1'b0,
    ACC = 1'b1
  } state_t;

  state_t            state;
  logic [1:0]        rr_last;
  logic              lock_prev;
  logic [HOLD_W-1:0] hold_cnt;

  logic [3:0]        req_ext_c;
  logic [3:0]        we_ext_c;
  logic [3:0]        lock_ext_c;
  logic [1:0]        rr_win_c;
  logic [1:0]        win_c;
  logic              locked_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_wdata_c;

  // Pad to 4 bits so a 2-bit requester index never selects out of range
  assign req_ext_c  = {1'b0, bus.req};
  assign we_ext_c   = {1'b0, bus.we};
  assign lock_ext_c = {1'b0, bus.lock};

  // First requesting index after the last winner, wrapping mod 3
  always_comb begin
    rr_win_c = 2'd0;
    case (rr_last)
      2'd0:    rr_win_c = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      2'd1:    rr_win_c = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
      default: rr_win_c = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Lock is honoured only while the hold budget lasts; at the limit rotation is forced
  always_comb begin
    locked_c = lock_prev && req_ext_c[bus.owner] && (hold_cnt < HOLD_W'(MAX_HOLD));
    win_c    = locked_c ? bus.owner : rr_win_c;
  end

  always_comb begin
    win_addr_c  = bus.addr[0 +: ADDR_W];
    win_wdata_c = bus.wdata[0 +: DATA_W];
    case (win_c)
      2'd1: begin
        win_addr_c  = bus.addr[ADDR_W +: ADDR_W];
        win_wdata_c = bus.wdata[DATA_W +: DATA_W];
      end
      2'd2: begin
        win_addr_c  = bus.addr[2*ADDR_W +: ADDR_W];
        win_wdata_c = bus.wdata[2*DATA_W +: DATA_W];
      end
      default: begin
        win_addr_c  = bus.addr[0 +: ADDR_W];
        win_wdata_c = bus.wdata[0 +: DATA_W];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ARB;
      rr_last       <= 2'd2;
      lock_prev     <= 1'b0;
      hold_cnt      <= '0;
      bus.gnt       <= '0;
      bus.rvalid    <= '0;
      bus.rdata     <= '0;
      bus.owner     <= 2'd0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.rvalid <= '0;
      case (state)
        ARB: begin
          if (bus.req != '0) begin
            bus.gnt       <= NREQ'(1) << win_c;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= we_ext_c[win_c];
            bus.mem_addr  <= win_addr_c;
            bus.mem_wdata <= win_wdata_c;
            bus.owner     <= win_c;
            rr_last       <= win_c;
            lock_prev     <= lock_ext_c[win_c];
            hold_cnt      <= locked_c ? hold_cnt + HOLD_W'(1) : HOLD_W'(1);
            state         <= ACC;
          end
        end
        ACC: begin
          // Memory data is captured here; the grant pulse shape doubles as the rvalid pattern
          if (!bus.mem_we) begin
            bus.rvalid <= bus.gnt;
            bus.rdata  <= bus.mem_rdata;
          end
          bus.gnt    <= '0;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          state      <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.gnt));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.rvalid));
  a_en_with_gnt: assert property (@(posedge clk) disable iff (!rst) bus.mem_en == (bus.gnt != '0));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected grants
// and read returns; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Memory model: read data is presented during the access cycle so the
  // arbiter's end-of-access edge captures it; writes land on that same edge.
  logic [7:0] mem [0:65535];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         r;
    bit         w;
    logic [15:0] a;
    logic [7:0]  d;
    int         gap;
  } gexp_t;

  typedef struct {
    int         r;
    logic [7:0] d;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int g1_seen  = 0;
  int rv1_seen = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [2:0] onehot(int r);
    logic [2:0] v;
    v = 3'b001 << r;
    return v;
  endfunction

  // Monitor
  gexp_t ge;
  rexp_t re;
  int    last_gnt_cyc = -100;
  initial forever begin
    @(negedge clk);
    chk("mem_en_vs_gnt", 32'(bus.mem_en), 32'(bus.gnt != 3'b000));
    if (bus.gnt[1]) g1_seen++;
    if (bus.rvalid[1]) rv1_seen++;
    if (bus.gnt != 3'b000) begin
      if (gq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_gnt: got gnt=%b, expected none", bus.gnt);
      end else begin
        ge = gq.pop_front();
        chk("gnt", 32'(bus.gnt), 32'(onehot(ge.r)));
        chk("owner", 32'(bus.owner), 32'(ge.r));
        chk("mem_we", 32'(bus.mem_we), 32'(ge.w));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ge.a));
        if (ge.w) chk("mem_wdata", 32'(bus.mem_wdata), 32'(ge.d));
        if (ge.gap != 0) chk("gnt_gap", 32'(cyc - last_gnt_cyc), 32'(ge.gap));
      end
      last_gnt_cyc = cyc;
    end
    if (bus.rvalid != 3'b000) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rvalid=%b, expected none", bus.rvalid);
      end else begin
        re = rq.pop_front();
        chk("rvalid", 32'(bus.rvalid), 32'(onehot(re.r)));
        chk("rdata", 32'(bus.rdata), 32'(re.d));
        chk("rvalid_latency", 32'(cyc - last_gnt_cyc), 32'd1);
      end
    end
  end

  task automatic push_g(input int r, input bit w, input logic [15:0] a, input logic [7:0] d,
                        input int gap);
    gexp_t e;
    e.r = r; e.w = w; e.a = a; e.d = d; e.gap = gap;
    gq.push_back(e);
  endtask

  task automatic push_r(input int r, input logic [7:0] d);
    rexp_t e;
    e.r = r; e.d = d;
    rq.push_back(e);
  endtask

  task automatic set_req(input int r, input bit w, input logic [15:0] a, input logic [7:0] d,
                         input bit lk);
    bus.addr[r*16 +: 16] = a;
    bus.wdata[r*8 +: 8]  = d;
    bus.we[r]            = w;
    bus.lock[r]          = lk;
    bus.req[r]           = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.gnt[r]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL gnt_timeout_r%0d: got no gnt, expected gnt within 40 cycles", r);
    end
  endtask

  task automatic wait_any(output logic [2:0] g, output bit ok);
    ok = 1'b0;
    g  = 3'b000;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.gnt != 3'b000) begin
        g  = bus.gnt;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL gnt_timeout_any: got no gnt, expected a gnt within 40 cycles");
    end
  endtask

  task automatic single(input int r, input bit w, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd);
    bit ok;
    push_g(r, w, a, d, 0);
    if (!w) push_r(r, exp_rd);
    set_req(r, w, a, d, 1'b0);
    wait_gnt(r, ok);
    bus.req[r] = 1'b0;
    idle(3);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    chk({tag, "_owner"}, 32'(bus.owner), 32'd0);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] g;
    bit         ok;
    int         n2;
    int         g1_base;
    int         rv1_base;

    bus.req   = '0;
    bus.we    = '0;
    bus.lock  = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    mem[16'h0010] = 8'hA5;
    mem[16'h0100] = 8'h11;
    mem[16'h0200] = 8'h22;
    mem[16'h0300] = 8'h33;
    mem[16'h1234] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    // T1: single read, requester 0 first after reset
    single(0, 1'b0, 16'h0010, 8'h00, 8'hA5);

    // T4: write by requester 1, then read back by requester 0
    single(1, 1'b1, 16'h1234, 8'h5A, 8'h00);
    single(0, 1'b0, 16'h1234, 8'h00, 8'h5A);
    chk("rdata_hold", 32'(bus.rdata), 32'h5A);
    chk("rvalid_idle", 32'(bus.rvalid), 32'd0);

    // T3: bounded lock, requester 2 wins first (last winner 0), four grants, then 0, then 2
    for (int k = 0; k < 4; k++) begin
      push_g(2, 1'b0, 16'h0300, 8'h00, (k == 0) ? 0 : 2);
      push_r(2, 8'h33);
    end
    push_g(0, 1'b0, 16'h0100, 8'h00, 2);
    push_r(0, 8'h11);
    push_g(2, 1'b0, 16'h0300, 8'h00, 2);
    push_r(2, 8'h33);
    set_req(0, 1'b0, 16'h0100, 8'h00, 1'b0);
    set_req(2, 1'b0, 16'h0300, 8'h00, 1'b1);
    n2 = 0;
    for (int k = 0; k < 6; k++) begin
      wait_any(g, ok);
      if (!ok) break;
      if (g[2]) begin
        n2++;
        if (n2 == 4) bus.lock[2] = 1'b0;
        if (n2 >= 5) bus.req[2] = 1'b0;
      end
      if (g[0]) bus.req[0] = 1'b0;
    end
    bus.req  = '0;
    bus.lock = '0;
    idle(4);

    // T2: round-robin with all three requesting, last winner 2
    for (int k = 0; k < 6; k++) begin
      push_g(k % 3, 1'b0, 16'((k % 3 + 1) * 16'h0100), 8'h00, (k == 0) ? 0 : 2);
      push_r(k % 3, 8'((k % 3 + 1) * 8'h11));
    end
    set_req(0, 1'b0, 16'h0100, 8'h00, 1'b0);
    set_req(1, 1'b0, 16'h0200, 8'h00, 1'b0);
    set_req(2, 1'b0, 16'h0300, 8'h00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      wait_any(g, ok);
      if (!ok) break;
    end
    bus.req = '0;
    idle(4);

    // Move last winner to 1 so requester 2 beats requester 1 next
    single(1, 1'b1, 16'h0400, 8'h77, 8'h00);

    // T5: requester 1 withdraws while requester 2 is served
    g1_base  = g1_seen;
    rv1_base = rv1_seen;
    push_g(2, 1'b0, 16'h0300, 8'h00, 0);
    push_r(2, 8'h33);
    set_req(1, 1'b0, 16'h0200, 8'h00, 1'b0);
    set_req(2, 1'b0, 16'h0300, 8'h00, 1'b0);
    wait_gnt(2, ok);
    bus.req = '0;
    idle(8);
    chk("t5_no_gnt1", 32'(g1_seen - g1_base), 32'd0);
    chk("t5_no_rvalid1", 32'(rv1_seen - rv1_base), 32'd0);

    // T6: reset during the access cycle of a read
    set_req(0, 1'b0, 16'h0010, 8'h00, 1'b0);
    wait_gnt(0, ok);
    chk("t6_gnt_before_reset", 32'(bus.gnt), 32'h1);
    rst = 1'b0;
    #1;
    chk_outputs_zero("t6_reset");
    set_req(1, 1'b0, 16'h0200, 8'h00, 1'b0);
    set_req(2, 1'b0, 16'h0300, 8'h00, 1'b0);
    idle(3);
    chk("t6_rvalid_in_reset", 32'(bus.rvalid), 32'd0);
    push_g(0, 1'b0, 16'h0010, 8'h00, 0);
    push_r(0, 8'hA5);
    rst = 1'b1;
    wait_gnt(0, ok);
    chk("t6_first_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    idle(5);

    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("rd_queue_drained", 32'(rq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
